rv_exit_monitor: RTL and testbench

// - Synthesizable riscv-tests completion monitor for 1..NUM_HARTS cores. Replaces hierarchical register-file peeks in benches.
// - Snoops each hart's writeback, retire and store ports. Detects exit via ecall (a7==SYS_EXIT) and/or a tohost store.
// - Latches pass/fail/timeout, per-hart exit codes, and cycle/instret counts.
// - Sits beside the core in the top-level; usable in simulation and on FPGA (status to LEDs/UART).

---
 rtl/rv_exit_pkg.sv | 29 ++
 rtl/rv_exit_hart_tracker.sv | 131 +++++++++++++
 rtl/rv_exit_monitor.sv | 155 +++++++++++++++
 tb/tb_rv_exit_monitor.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_exit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_exit_pkg
// Purpose  : Shared constants and state types for the riscv-tests completion
//            monitor (rv_exit_monitor and rv_exit_hart_tracker).
// Contents : A0_IDX / A7_IDX   - architectural register indices of a0 and a7
//            mon_state_e       - global monitor state
//            hart_state_e      - per-hart exit tracker state
// Revision : 1.0 - initial release
// ============================================================================
package rv_exit_pkg;

    localparam logic [4:0] A0_IDX = 5'd10;
    localparam logic [4:0] A7_IDX = 5'd17;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PASS    = 2'd1,
        FAIL    = 2'd2,
        TIMEOUT = 2'd3
    } mon_state_e;

    typedef enum logic [0:0] {
        H_RUN    = 1'b0,
        H_EXITED = 1'b1
    } hart_state_e;

endpackage
`default_nettype wire

// File: rtl/rv_exit_hart_tracker.sv
`default_nettype none
// ============================================================================
// Module   : rv_exit_hart_tracker
// Purpose  : Per-hart exit tracker. Shadows a0/a7 from the writeback port,
//            detects an ecall exit and/or a tohost store exit, latches the
//            exit code and counts retired instructions until exit.
// Ports    : clk_i, rst_i          clock, synchronous active-high reset
//            wb_valid_i/rd/data    register writeback snoop
//            retire_i, ecall_i     retire snoop
//            st_valid_i/addr/data  store snoop
//            exit_o                exit event this cycle (combinational)
//            exit_ok_o             that exit carries code 0 (combinational)
//            exited_ok_o           hart already exited with code 0 (registered)
//            code_o                latched exit code
//            instret_o             retired-instruction count (frozen on exit)
// Revision : 1.0 - initial release
// ============================================================================
module rv_exit_hart_tracker
    import rv_exit_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned CNT_W       = 64,
    parameter logic [31:0] SYS_EXIT    = 32'h5d,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
    parameter logic [1:0]  MODE        = 2'b11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wb_valid_i,
    input  logic [4:0]       wb_rd_i,
    input  logic [XLEN-1:0]  wb_data_i,
    input  logic             retire_i,
    input  logic             ecall_i,
    input  logic             st_valid_i,
    input  logic [XLEN-1:0]  st_addr_i,
    input  logic [XLEN-1:0]  st_data_i,
    output logic             exit_o,
    output logic             exit_ok_o,
    output logic             exited_ok_o,
    output logic [XLEN-1:0]  code_o,
    output logic [CNT_W-1:0] instret_o
);

    hart_state_e      state_q, state_d;
    logic [XLEN-1:0]  a0_q, a0_d;
    logic [XLEN-1:0]  a7_q, a7_d;
    logic [XLEN-1:0]  code_q, code_d;
    logic             ok_q, ok_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic             w_wb_a0;
    logic             w_wb_a7;
    logic [XLEN-1:0]  w_a0;
    logic [XLEN-1:0]  w_a7;
    logic             w_ecall_hit;
    logic             w_tohost_hit;
    logic [XLEN-1:0]  w_code;
    logic             w_ok;
    logic             w_exit;

    // rd=0 never matches either index, so x0 writes fall out naturally.
    assign w_wb_a0 = wb_valid_i && (wb_rd_i == A0_IDX);
    assign w_wb_a7 = wb_valid_i && (wb_rd_i == A7_IDX);

    // Bypass so an ecall retiring alongside the writeback sees the new value.
    assign w_a0 = w_wb_a0 ? wb_data_i : a0_q;
    assign w_a7 = w_wb_a7 ? wb_data_i : a7_q;

    assign w_ecall_hit  = MODE[0] && retire_i && ecall_i && (w_a7 == XLEN'(SYS_EXIT));
    assign w_tohost_hit = MODE[1] && st_valid_i && (st_addr_i == XLEN'(TOHOST_ADDR))
                          && st_data_i[0];

    assign w_exit = (state_q == H_RUN) && (w_ecall_hit || w_tohost_hit);

    // Ecall takes precedence if both mechanisms fire in the same cycle.
    always_comb begin
        w_code = '0;
        w_ok   = 1'b0;
        if (w_ecall_hit) begin
            w_code = w_a0 >> 1;
            w_ok   = (w_a0 == '0);
        end else if (w_tohost_hit) begin
            w_code = st_data_i >> 1;
            w_ok   = ((st_data_i >> 1) == '0);
        end
    end

    always_comb begin
        state_d   = state_q;
        a0_d      = w_a0;
        a7_d      = w_a7;
        code_d    = code_q;
        ok_d      = ok_q;
        instret_d = instret_q;
        if (w_exit) begin
            state_d = H_EXITED;
            code_d  = w_code;
            ok_d    = w_ok;
        end
        // The exiting retire still counts: state_q is H_RUN in that cycle.
        if (retire_i && (state_q == H_RUN) && (instret_q != '1)) begin
            instret_d = instret_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= H_RUN;
            a0_q      <= '0;
            a7_q      <= '0;
            code_q    <= '0;
            ok_q      <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            a0_q      <= a0_d;
            a7_q      <= a7_d;
            code_q    <= code_d;
            ok_q      <= ok_d;
            instret_q <= instret_d;
        end
    end

    assign exit_o      = w_exit;
    assign exit_ok_o   = w_ok;
    assign exited_ok_o = (state_q == H_EXITED) && ok_q;
    assign code_o      = code_q;
    assign instret_o   = instret_q;

endmodule
`default_nettype wire

// File: rtl/rv_exit_monitor.sv
`default_nettype none
// ============================================================================
// Module   : rv_exit_monitor
// Purpose  : riscv-tests completion monitor for NUM_HARTS cores. Snoops each
//            hart's writeback, retire and store ports and latches a sticky
//            pass / fail / timeout verdict with per-hart exit codes and
//            cycle / instret counts.
// Ports    : clk_i, rst_i              clock, synchronous active-high reset
//            wb_*_i, retire_i,         per-hart snoop inputs (packed, hart h
//            ecall_i, st_*_i           at slice [h*W +: W])
//            done_o/pass_o/fail_o/     sticky registered verdict flags
//            timeout_o
//            fail_hart_o               lowest failing hart index
//            exit_code_o               per-hart exit code (raw >> 1)
//            cycles_o                  cycles from reset release to done
//            instret_o                 per-hart retired-instruction count
// Revision : 1.0 - initial release
// ============================================================================
module rv_exit_monitor
    import rv_exit_pkg::*;
#(
    parameter int unsigned NUM_HARTS   = 1,
    parameter int unsigned XLEN        = 32,
    parameter int unsigned CNT_W       = 64,
    parameter logic [31:0] SYS_EXIT    = 32'h5d,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000,
    parameter logic [1:0]  MODE        = 2'b11,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_HARTS-1:0]           wb_valid_i,
    input  logic [5*NUM_HARTS-1:0]         wb_rd_i,
    input  logic [XLEN*NUM_HARTS-1:0]      wb_data_i,
    input  logic [NUM_HARTS-1:0]           retire_i,
    input  logic [NUM_HARTS-1:0]           ecall_i,
    input  logic [NUM_HARTS-1:0]           st_valid_i,
    input  logic [XLEN*NUM_HARTS-1:0]      st_addr_i,
    input  logic [XLEN*NUM_HARTS-1:0]      st_data_i,
    output logic                           done_o,
    output logic                           pass_o,
    output logic                           fail_o,
    output logic                           timeout_o,
    output logic [$clog2(NUM_HARTS):0]     fail_hart_o,
    output logic [XLEN*NUM_HARTS-1:0]      exit_code_o,
    output logic [CNT_W-1:0]               cycles_o,
    output logic [CNT_W*NUM_HARTS-1:0]     instret_o
);

    localparam int unsigned FH_W = $clog2(NUM_HARTS) + 1;
    // Last cycle index before the watchdog fires; unused when disabled.
    localparam logic [CNT_W-1:0] WD_LAST =
        (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

    logic [NUM_HARTS-1:0] w_exit;
    logic [NUM_HARTS-1:0] w_exit_ok;
    logic [NUM_HARTS-1:0] w_exited_ok;

    generate
        for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
            rv_exit_hart_tracker #(
                .XLEN        (XLEN),
                .CNT_W       (CNT_W),
                .SYS_EXIT    (SYS_EXIT),
                .TOHOST_ADDR (TOHOST_ADDR),
                .MODE        (MODE)
            ) u_tracker (
                .clk_i       (clk_i),
                .rst_i       (rst_i),
                .wb_valid_i  (wb_valid_i[h]),
                .wb_rd_i     (wb_rd_i[h*5 +: 5]),
                .wb_data_i   (wb_data_i[h*XLEN +: XLEN]),
                .retire_i    (retire_i[h]),
                .ecall_i     (ecall_i[h]),
                .st_valid_i  (st_valid_i[h]),
                .st_addr_i   (st_addr_i[h*XLEN +: XLEN]),
                .st_data_i   (st_data_i[h*XLEN +: XLEN]),
                .exit_o      (w_exit[h]),
                .exit_ok_o   (w_exit_ok[h]),
                .exited_ok_o (w_exited_ok[h]),
                .code_o      (exit_code_o[h*XLEN +: XLEN]),
                .instret_o   (instret_o[h*CNT_W +: CNT_W])
            );
        end
    endgenerate

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [FH_W-1:0]  fail_hart_q, fail_hart_d;

    logic             w_fail_any;
    logic             w_all_ok;
    logic             w_any_exit;
    logic             w_wd_hit;
    logic [FH_W-1:0]  w_fail_idx;

    assign w_fail_any = |(w_exit & ~w_exit_ok);
    // A hart counts as good if it exited cleanly earlier or does so now.
    assign w_all_ok   = &(w_exited_ok | (w_exit & w_exit_ok));
    assign w_any_exit = |w_exit;
    // ">=" rather than "==": a clean partial exit on the limit cycle defers
    // the timeout by a cycle instead of disarming the watchdog for good.
    assign w_wd_hit   = (TIMEOUT_CYC != 0) && (cycles_q >= WD_LAST);

    // Scan high to low so the lowest failing index is the one left standing.
    always_comb begin
        w_fail_idx = '0;
        for (int h = NUM_HARTS - 1; h >= 0; h--) begin
            if (w_exit[h] && !w_exit_ok[h]) begin
                w_fail_idx = FH_W'(h);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cycles_d    = cycles_q;
        fail_hart_d = fail_hart_q;
        if (state_q == RUN) begin
            if (w_fail_any) begin
                state_d     = FAIL;
                fail_hart_d = w_fail_idx;
            end else if (w_all_ok) begin
                state_d = PASS;
            end else if (!w_any_exit && w_wd_hit) begin
                state_d = TIMEOUT;
            end else if (cycles_q != '1) begin
                // Only cycles that stay in RUN advance the count, so the
                // terminal value equals the index of the deciding cycle.
                cycles_d = cycles_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            cycles_q    <= '0;
            fail_hart_q <= '0;
        end else begin
            state_q     <= state_d;
            cycles_q    <= cycles_d;
            fail_hart_q <= fail_hart_d;
        end
    end

    assign done_o      = (state_q != RUN);
    assign pass_o      = (state_q == PASS);
    assign fail_o      = (state_q == FAIL);
    assign timeout_o   = (state_q == TIMEOUT);
    assign fail_hart_o = fail_hart_q;
    assign cycles_o    = cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_rv_exit_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_exit_monitor
// Purpose  : Directed self-checking bench for rv_exit_monitor. One single-hart
//            instance (watchdog 50 cycles) and one two-hart instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_exit_monitor;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-hart instance
    logic         rst1;
    logic [0:0]   wbv1, ret1, ec1, stv1;
    logic [4:0]   wbrd1;
    logic [31:0]  wbd1, sta1, std1;
    logic         done1, pass1, fail1, to1;
    logic [0:0]   fh1;
    logic [31:0]  code1;
    logic [63:0]  cyc1, ir1;

    // Two-hart instance
    logic         rst2;
    logic [1:0]   wbv2, ret2, ec2, stv2;
    logic [9:0]   wbrd2;
    logic [63:0]  wbd2, sta2, std2;
    logic         done2, pass2, fail2, to2;
    logic [1:0]   fh2;
    logic [63:0]  code2;
    logic [63:0]  cyc2;
    logic [127:0] ir2;

    rv_exit_monitor #(
        .NUM_HARTS   (1),
        .TIMEOUT_CYC (50)
    ) u_dut1 (
        .clk_i       (clk),
        .rst_i       (rst1),
        .wb_valid_i  (wbv1),
        .wb_rd_i     (wbrd1),
        .wb_data_i   (wbd1),
        .retire_i    (ret1),
        .ecall_i     (ec1),
        .st_valid_i  (stv1),
        .st_addr_i   (sta1),
        .st_data_i   (std1),
        .done_o      (done1),
        .pass_o      (pass1),
        .fail_o      (fail1),
        .timeout_o   (to1),
        .fail_hart_o (fh1),
        .exit_code_o (code1),
        .cycles_o    (cyc1),
        .instret_o   (ir1)
    );

    rv_exit_monitor #(
        .NUM_HARTS   (2),
        .TIMEOUT_CYC (1000)
    ) u_dut2 (
        .clk_i       (clk),
        .rst_i       (rst2),
        .wb_valid_i  (wbv2),
        .wb_rd_i     (wbrd2),
        .wb_data_i   (wbd2),
        .retire_i    (ret2),
        .ecall_i     (ec2),
        .st_valid_i  (stv2),
        .st_addr_i   (sta2),
        .st_data_i   (std2),
        .done_o      (done2),
        .pass_o      (pass2),
        .fail_o      (fail2),
        .timeout_o   (to2),
        .fail_hart_o (fh2),
        .exit_code_o (code2),
        .cycles_o    (cyc2),
        .instret_o   (ir2)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle1();
        wbv1 = '0; wbrd1 = '0; wbd1 = '0; ret1 = '0; ec1 = '0;
        stv1 = '0; sta1 = '0; std1 = '0;
    endtask

    task automatic idle2();
        wbv2 = '0; wbrd2 = '0; wbd2 = '0; ret2 = '0; ec2 = '0;
        stv2 = '0; sta2 = '0; std2 = '0;
    endtask

    task automatic reset1();
        idle1();
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
    endtask

    task automatic reset2();
        idle2();
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
    endtask

    initial begin
        rst1 = 1'b1;
        rst2 = 1'b1;
        idle1();
        idle2();
        @(negedge clk);
        repeat (2) tick();

        // ---------------- reset state ----------------
        chk("rst1_done",    64'(done1), 64'd0);
        chk("rst1_pass",    64'(pass1), 64'd0);
        chk("rst1_cycles",  cyc1,       64'd0);
        chk("rst2_done",    64'(done2), 64'd0);
        chk("rst2_instret", ir2[63:0],  64'd0);
        rst1 = 1'b0;

        // ---------------- ecall pass ----------------
        wbv1 = 1'b1; wbrd1 = 5'd17; wbd1 = 32'h5d; tick(); idle1();
        wbv1 = 1'b1; wbrd1 = 5'd10; wbd1 = 32'h0;  tick(); idle1();
        chk("pass_not_yet", 64'(done1), 64'd0);
        ret1 = 1'b1; ec1 = 1'b1; tick(); idle1();
        chk("pass_pass",    64'(pass1), 64'd1);
        chk("pass_done",    64'(done1), 64'd1);
        chk("pass_fail",    64'(fail1), 64'd0);
        chk("pass_code",    64'(code1), 64'd0);
        chk("pass_cycles",  cyc1,       64'd2);
        chk("pass_instret", ir1,        64'd1);
        tick();
        chk("pass_cycles_frozen", cyc1, 64'd2);

        // ---------------- reset after done ----------------
        rst1 = 1'b1; tick();
        chk("rstmid_done",    64'(done1), 64'd0);
        chk("rstmid_pass",    64'(pass1), 64'd0);
        chk("rstmid_cycles",  cyc1,       64'd0);
        chk("rstmid_instret", ir1,        64'd0);
        rst1 = 1'b0;

        // ---------------- ecall fail with a0 bypass ----------------
        wbv1 = 1'b1; wbrd1 = 5'd17; wbd1 = 32'h5d; tick(); idle1();
        wbv1 = 1'b1; wbrd1 = 5'd10; wbd1 = 32'h7; ret1 = 1'b1; ec1 = 1'b1;
        tick(); idle1();
        chk("fail_fail", 64'(fail1), 64'd1);
        chk("fail_pass", 64'(pass1), 64'd0);
        chk("fail_code", 64'(code1), 64'd3);
        chk("fail_hart", 64'(fh1),   64'd0);
        // A later clean exit on the same hart is ignored
        wbv1 = 1'b1; wbrd1 = 5'd10; wbd1 = 32'h0; ret1 = 1'b1; ec1 = 1'b1;
        tick(); idle1();
        chk("fail_sticky",       64'(fail1), 64'd1);
        chk("fail_code_frozen",  64'(code1), 64'd3);
        chk("fail_instret_frz",  ir1,        64'd1);

        // ---------------- x0 writes never trigger, next run works ----------------
        reset1();
        wbv1 = 1'b1; wbrd1 = 5'd0; wbd1 = 32'h5d; ret1 = 1'b1; ec1 = 1'b1;
        tick(); idle1();
        chk("x0_no_exit", 64'(done1), 64'd0);
        wbv1 = 1'b1; wbrd1 = 5'd17; wbd1 = 32'h5d; ret1 = 1'b1; ec1 = 1'b1;
        tick(); idle1();
        chk("rerun_pass",    64'(pass1), 64'd1);
        chk("rerun_instret", ir1,        64'd2);

        // ---------------- tohost ----------------
        reset1();
        stv1 = 1'b1; sta1 = 32'h1000; std1 = 32'h2; tick(); idle1();
        chk("tohost_even_ignored", 64'(done1), 64'd0);
        stv1 = 1'b1; sta1 = 32'h1004; std1 = 32'h1; tick(); idle1();
        chk("tohost_wrong_addr",   64'(done1), 64'd0);
        stv1 = 1'b1; sta1 = 32'h1000; std1 = 32'h1; tick(); idle1();
        chk("tohost_pass",         64'(pass1), 64'd1);
        chk("tohost_pass_code",    64'(code1), 64'd0);
        reset1();
        stv1 = 1'b1; sta1 = 32'h1000; std1 = 32'h7; tick(); idle1();
        chk("tohost_fail",         64'(fail1), 64'd1);
        chk("tohost_fail_code",    64'(code1), 64'd3);

        // ---------------- watchdog ----------------
        reset1();
        repeat (49) tick();
        chk("wd_before_done",  64'(done1), 64'd0);
        chk("wd_before_cyc",   cyc1,       64'd49);
        tick();
        chk("wd_timeout",      64'(to1),   64'd1);
        chk("wd_done",         64'(done1), 64'd1);
        chk("wd_no_pass",      64'(pass1), 64'd0);
        chk("wd_cycles",       cyc1,       64'd49);
        tick();
        chk("wd_cycles_frozen", cyc1,      64'd49);

        // Exit on the limit cycle beats the watchdog
        reset1();
        wbv1 = 1'b1; wbrd1 = 5'd17; wbd1 = 32'h5d; tick(); idle1();
        repeat (48) tick();
        ret1 = 1'b1; ec1 = 1'b1; tick(); idle1();
        chk("wdx_pass",    64'(pass1), 64'd1);
        chk("wdx_no_to",   64'(to1),   64'd0);
        chk("wdx_cycles",  cyc1,       64'd49);

        // ---------------- two harts: staggered clean exits ----------------
        rst2 = 1'b0;
        wbv2 = 2'b11; wbrd2 = {5'd17, 5'd17}; wbd2 = {32'h5d, 32'h5d}; ret2 = 2'b11;
        tick(); idle2();
        ret2 = 2'b11; repeat (9) tick();
        ret2 = 2'b11; ec2 = 2'b10; tick(); idle2();
        chk("mh_c10_done",   64'(done2),  64'd0);
        chk("mh_c10_ir1",    ir2[127:64], 64'd11);
        chk("mh_c10_ir0",    ir2[63:0],   64'd11);
        ret2 = 2'b11; repeat (9) tick(); idle2();
        chk("mh_c19_done",   64'(done2),  64'd0);
        chk("mh_c19_ir1",    ir2[127:64], 64'd11);
        chk("mh_c19_cycles", cyc2,        64'd20);
        ret2 = 2'b11; ec2 = 2'b01; tick(); idle2();
        chk("mh_pass",       64'(pass2),  64'd1);
        chk("mh_done",       64'(done2),  64'd1);
        chk("mh_cycles",     cyc2,        64'd20);
        chk("mh_ir0",        ir2[63:0],   64'd21);
        chk("mh_ir1",        ir2[127:64], 64'd11);
        chk("mh_codes",      code2,       64'd0);

        // ---------------- two harts failing in the same cycle ----------------
        reset2();
        wbv2 = 2'b11; wbrd2 = {5'd17, 5'd17}; wbd2 = {32'h5d, 32'h5d};
        tick(); idle2();
        wbv2 = 2'b01; wbrd2 = {5'd0, 5'd10}; wbd2 = {32'h0, 32'h5};
        ret2 = 2'b01; ec2 = 2'b01;
        stv2 = 2'b10; sta2 = {32'h1000, 32'h0}; std2 = {32'h9, 32'h0};
        tick(); idle2();
        chk("mhf_fail",  64'(fail2),    64'd1);
        chk("mhf_hart",  64'(fh2),      64'd0);
        chk("mhf_code0", code2[31:0],   64'd2);
        chk("mhf_code1", code2[63:32],  64'd4);

        // ---------------- only hart1 failing ----------------
        reset2();
        stv2 = 2'b10; sta2 = {32'h1000, 32'h0}; std2 = {32'h3, 32'h0};
        tick(); idle2();
        chk("mh1_fail",  64'(fail2),    64'd1);
        chk("mh1_hart",  64'(fh2),      64'd1);
        chk("mh1_code1", code2[63:32],  64'd1);
        chk("mh1_no_to", 64'(to2),      64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
